// File: rtl/dcf77_time_counter.sv
// BCD hh:mm:ss time-of-day keeper advanced by a 1 Hz tick and realigned by decoded DCF77 frames.
// Optional alarm comparator enabled with `define DCF77_ALARM_EN.
module dcf77_time_counter #(
  parameter int unsigned SYNC_TIMEOUT_MIN = 60
) (
  input  logic       clk10,
  input  logic       reset,
  input  logic       tick,
  input  logic       load_valid,
  input  logic [6:0] load_min,
  input  logic [5:0] load_hour,
`ifdef DCF77_ALARM_EN
  input  logic       alarm_en,
  input  logic [6:0] alarm_min,
  input  logic [5:0] alarm_hour,
  output logic       alarm,
`endif
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [5:0] hour,
  output logic       min_tick,
  output logic       synced,
  output logic       load_err
);

  localparam logic [7:0] TIMEOUT = 8'(SYNC_TIMEOUT_MIN);

  logic [7:0] timeout_cnt, timeout_cnt_d;
  logic [6:0] sec_d, min_d;
  logic [5:0] hour_d;
  logic       synced_d;
  logic       load_ok, accept, reject, advance, wrap;

  // 00..59 BCD counter step; callers only hold values that passed load validation.
  function automatic logic [6:0] inc_bcd60(input logic [6:0] v);
    if (v == 7'h59)          return 7'h00;
    else if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    else                     return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] inc_bcd24(input logic [5:0] v);
    if (v == 6'h23)          return 6'h00;
    else if (v[3:0] == 4'd9) return {v[5:4] + 2'd1, 4'd0};
    else                     return {v[5:4], v[3:0] + 4'd1};
  endfunction

  assign load_ok = (load_min[3:0]  <= 4'd9) && (load_min[6:4]  <= 3'd5) &&
                   (load_hour[3:0] <= 4'd9) && (load_hour[5:4] <= 2'd2) &&
                   !((load_hour[5:4] == 2'd2) && (load_hour[3:0] > 4'd3));

  // A valid load wins over a coincident tick; a rejected load lets the tick through.
  assign accept  = load_valid && load_ok;
  assign reject  = load_valid && !load_ok;
  assign advance = tick && !accept;
  assign wrap    = advance && (sec == 7'h59);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    sec_d         = sec;
    min_d         = min;
    hour_d        = hour;
    synced_d      = synced;
    timeout_cnt_d = timeout_cnt;
    if (accept) begin
      sec_d         = 7'h00;
      min_d         = load_min;
      hour_d        = load_hour;
      synced_d      = 1'b1;
      timeout_cnt_d = 8'd0;
    end else if (advance) begin
      sec_d = inc_bcd60(sec);
      if (wrap) begin
        min_d = inc_bcd60(min);
        if (min == 7'h59) hour_d = inc_bcd24(hour);
        // Counting stops once synced drops, so the counter holds at the limit.
        if (synced) begin
          timeout_cnt_d = timeout_cnt + 8'd1;
          if (timeout_cnt_d == TIMEOUT) synced_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk10) begin
    if (reset) begin
      sec         <= 7'h00;
      min         <= 7'h00;
      hour        <= 6'h00;
      min_tick    <= 1'b0;
      synced      <= 1'b0;
      load_err    <= 1'b0;
      timeout_cnt <= 8'd0;
    end else begin
      sec         <= sec_d;
      min         <= min_d;
      hour        <= hour_d;
      min_tick    <= wrap;
      synced      <= synced_d;
      load_err    <= reject;
      timeout_cnt <= timeout_cnt_d;
    end
  end

`ifdef DCF77_ALARM_EN
  // Compared against the post-wrap time so the pulse lines up with min_tick.
  always_ff @(posedge clk10) begin
    if (reset) alarm <= 1'b0;
    else       alarm <= wrap && alarm_en && (min_d == alarm_min) && (hour_d == alarm_hour);
  end
`endif

endmodule

// File: tb/tb_dcf77_time_counter.sv
// Self-checking bench for dcf77_time_counter: vector table for loads, hand sequences for minute wraps.
// Alarm checks are compiled in when DCF77_ALARM_EN is defined.
module tb_dcf77_time_counter;

  logic       clk10 = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       load_valid = 1'b0;
  logic [6:0] load_min = 7'h00;
  logic [5:0] load_hour = 6'h00;
  logic [6:0] sec, min;
  logic [5:0] hour;
  logic       min_tick, synced, load_err;
`ifdef DCF77_ALARM_EN
  logic       alarm_en = 1'b1;
  logic [6:0] alarm_min = 7'h45;
  logic [5:0] alarm_hour = 6'h06;
  logic       alarm;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dcf77_time_counter #(.SYNC_TIMEOUT_MIN(2)) dut (
    .clk10      (clk10),
    .reset      (reset),
    .tick       (tick),
    .load_valid (load_valid),
    .load_min   (load_min),
    .load_hour  (load_hour),
`ifdef DCF77_ALARM_EN
    .alarm_en   (alarm_en),
    .alarm_min  (alarm_min),
    .alarm_hour (alarm_hour),
    .alarm      (alarm),
`endif
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .min_tick   (min_tick),
    .synced     (synced),
    .load_err   (load_err)
  );

  always #50 clk10 = ~clk10;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       tk;
    logic       lv;
    logic [6:0] lm;
    logic [5:0] lh;
    logic [6:0] e_sec;
    logic [6:0] e_min;
    logic [5:0] e_hour;
    logic       e_mt;
    logic       e_sync;
    logic       e_err;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [6:0] bcd(input int v);
    return 7'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] e_sec, input logic [6:0] e_min,
                           input logic [5:0] e_hour, input logic e_mt, input logic e_sync,
                           input logic e_err);
    check({tag, " sec"},      32'(sec),      32'(e_sec));
    check({tag, " min"},      32'(min),      32'(e_min));
    check({tag, " hour"},     32'(hour),     32'(e_hour));
    check({tag, " min_tick"}, 32'(min_tick), 32'(e_mt));
    check({tag, " synced"},   32'(synced),   32'(e_sync));
    check({tag, " load_err"}, 32'(load_err), 32'(e_err));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
  task automatic apply(input logic t, input logic lv, input logic [6:0] lm, input logic [5:0] lh);
    tick       = t;
    load_valid = lv;
    load_min   = lm;
    load_hour  = lh;
    @(posedge clk10);
    #1;
    tick       = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 7'h60, 6'h12, 7'h01, 7'h01, 6'h00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 7'h00, 6'h00, 7'h01, 7'h01, 6'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 7'h1A, 6'h05, 7'h01, 7'h01, 6'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 7'h10, 6'h24, 7'h01, 7'h01, 6'h00, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 7'h10, 6'h30, 7'h01, 7'h01, 6'h00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 7'h10, 6'h0F, 7'h01, 7'h01, 6'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 7'h30, 6'h12, 7'h00, 7'h30, 6'h12, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 7'h60, 6'h12, 7'h01, 7'h30, 6'h12, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 7'h00, 6'h00, 7'h01, 7'h30, 6'h12, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 7'h45, 6'h09, 7'h00, 7'h45, 6'h09, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 7'h00, 6'h20, 7'h00, 7'h00, 6'h20, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 7'h59, 6'h2A, 7'h00, 7'h00, 6'h20, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 7'h00, 6'h00, 7'h01, 7'h00, 6'h20, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 7'h59, 6'h23, 7'h00, 7'h59, 6'h23, 1'b0, 1'b1, 1'b0};

    // Reset overrides a coincident tick and valid load.
    @(posedge clk10);
    #1;
    reset = 1'b1;
    apply(1'b1, 1'b1, 7'h30, 6'h12);
    apply(1'b1, 1'b0, 7'h00, 6'h00);
    reset = 1'b0;
    check_all("reset", 7'h00, 7'h00, 6'h00, 1'b0, 1'b0, 1'b0);
`ifdef DCF77_ALARM_EN
    check("reset alarm", 32'(alarm), 32'd0);
`endif

    // 61 ticks from reset: seconds 01..59, 00 with min_tick, then 01.
    for (int i = 1; i <= 61; i++) begin
      apply(1'b1, 1'b0, 7'h00, 6'h00);
      check_all($sformatf("count61 t%0d", i), bcd(i % 60), (i >= 60) ? 7'h01 : 7'h00,
                6'h00, (i == 60), 1'b0, 1'b0);
    end

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].tk, vecs[i].lv, vecs[i].lm, vecs[i].lh);
      check_all($sformatf("vec%0d", i), vecs[i].e_sec, vecs[i].e_min, vecs[i].e_hour,
                vecs[i].e_mt, vecs[i].e_sync, vecs[i].e_err);
    end

    // From 23:59:00, 60 ticks roll over to 00:00:00 with a single min_tick.
    for (int i = 1; i <= 60; i++) begin
      apply(1'b1, 1'b0, 7'h00, 6'h00);
      check_all($sformatf("midnight t%0d", i), bcd(i % 60), (i < 60) ? 7'h59 : 7'h00,
                (i < 60) ? 6'h23 : 6'h00, (i == 60), 1'b1, 1'b0);
    end
    apply(1'b0, 1'b0, 7'h00, 6'h00);
    check("midnight min_tick drop", 32'(min_tick), 32'd0);

    // Hour units carry 09 -> 10.
    apply(1'b0, 1'b1, 7'h59, 6'h09);
    for (int i = 0; i < 60; i++) apply(1'b1, 1'b0, 7'h00, 6'h00);
    check_all("carry09", 7'h00, 7'h00, 6'h10, 1'b1, 1'b1, 1'b0);

    // Sync timeout of 2 minutes from 19:59:00, also covering 19 -> 20.
    apply(1'b0, 1'b1, 7'h59, 6'h19);
    check_all("timeout load", 7'h00, 7'h59, 6'h19, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 120; i++) begin
      apply(1'b1, 1'b0, 7'h00, 6'h00);
      check_all($sformatf("timeout t%0d", i), bcd(i % 60),
                (i < 60) ? 7'h59 : ((i < 120) ? 7'h00 : 7'h01),
                (i < 60) ? 6'h19 : 6'h20, (i % 60 == 0), (i < 120), 1'b0);
    end
    for (int i = 1; i <= 60; i++) begin
      apply(1'b1, 1'b0, 7'h00, 6'h00);
      check($sformatf("timeout hold t%0d synced", i), 32'(synced), 32'd0);
    end
    check_all("timeout end", 7'h00, 7'h02, 6'h20, 1'b1, 1'b0, 1'b0);

`ifdef DCF77_ALARM_EN
    apply(1'b0, 1'b1, 7'h44, 6'h06);
    check("alarm after load 06:44", 32'(alarm), 32'd0);
    for (int i = 1; i <= 60; i++) begin
      apply(1'b1, 1'b0, 7'h00, 6'h00);
      check($sformatf("alarm t%0d", i), 32'(alarm), 32'(i == 60));
    end
    check("alarm min_tick", 32'(min_tick), 32'd1);
    apply(1'b0, 1'b0, 7'h00, 6'h00);
    check("alarm drop", 32'(alarm), 32'd0);
    apply(1'b0, 1'b1, 7'h45, 6'h06);
    check("alarm direct load", 32'(alarm), 32'd0);
    apply(1'b0, 1'b0, 7'h00, 6'h00);
    check("alarm direct load idle", 32'(alarm), 32'd0);
`endif

    // Synchronous reset in the middle of running time.
    reset = 1'b1;
    apply(1'b1, 1'b0, 7'h00, 6'h00);
    reset = 1'b0;
    check_all("reset again", 7'h00, 7'h00, 6'h00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
